// File: rtl/bin_to_bcd_digits_pkg.sv
// Shared display definitions: blank code, FSM encoding and a
// parameter-check helper for the BCD converter.
package bin_to_bcd_digits_pkg;

  // Nibble code the 7-segment decoder renders as all segments off.
  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // 10**n as a 64-bit constant, used to check that DIGITS covers BIN_W.
  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bin_to_bcd_digits_if.sv
// Request/result bundle between a requester and the BCD converter.
//
// Handshake: the master raises 'start' with 'bin' and 'blank_lz' valid;
// the request is taken on the first clock edge where start=1 and the
// converter is idle (busy=0). While busy=1 start is ignored. 'done' is a
// one-cycle pulse marking the cycle in which 'digits' first shows the new
// result; 'digits' then holds until the next done or reset. busy and done
// are never high together, and start during done is accepted.
interface bin_to_bcd_digits_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) ();
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  blank_lz;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   digits;

  modport master (output start, bin, blank_lz, input busy, done, digits);
  modport slave  (input start, bin, blank_lz, output busy, done, digits);
endinterface

// File: rtl/bin_to_bcd_digits_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added
// before the shift so that it carries correctly into the next digit.
module bcd_add3 (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);
  import bin_to_bcd_digits_pkg::*;

  // Correction stays within the nibble; values >= 5 never exceed 9 here.
  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/bin_to_bcd_digits.sv
// Sequential binary-to-BCD converter, one bit per clock, with optional
// leading-zero blanking for driving 7-segment decoders directly.
module bin_to_bcd_digits
  import bin_to_bcd_digits_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  bin_to_bcd_digits_if.slave   bus,
  output state_t               state_o
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
  localparam longint unsigned MAX_BIN = (64'd1 << BIN_W) - 64'd1;

  // DIGITS must be able to represent the largest BIN_W-bit value.
  if (pow10(DIGITS) <= MAX_BIN) begin : g_param_err
    $error("bin_to_bcd_digits: DIGITS too small for BIN_W");
  end

  state_t              state_q;
  logic                busy_q;
  logic                done_q;
  logic                blank_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [BIN_W-1:0]    shreg_q, shreg_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [BCD_W-1:0]    digits_q;
  logic [BCD_W-1:0]    corr;
  logic [BCD_W-1:0]    blanked;

  // One add-3 corrector per BCD digit.
  for (genvar d = 0; d < DIGITS; d++) begin : g_add3
    bcd_add3 u_add3 (
      .d_i (bcd_q[4*d +: 4]),
      .d_o (corr[4*d +: 4])
    );
  end

  // Next shift step: corrected BCD and shift register move left one bit together.
  always_comb begin
    bcd_d   = {corr[BCD_W-2:0], shreg_q[BIN_W-1]};
    shreg_d = {shreg_q[BIN_W-2:0], 1'b0};
  end

  // Leading-zero blanking from the MS digit down; digit 0 always shows.
  always_comb begin
    logic lead;
    blanked = bcd_q;
    lead    = blank_q;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (lead && (bcd_q[4*d +: 4] == 4'd0)) begin
        blanked[4*d +: 4] = BLANK_CODE;
      end else begin
        lead = 1'b0;
      end
    end
  end

  // Control FSM with registered busy/done/digits; reset darkens the display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      blank_q  <= 1'b0;
      cnt_q    <= '0;
      shreg_q  <= '0;
      bcd_q    <= '0;
      digits_q <= {DIGITS{BLANK_CODE}};
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            shreg_q <= bus.bin;
            bcd_q   <= '0;
            cnt_q   <= '0;
            blank_q <= bus.blank_lz;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bcd_q   <= bcd_d;
          shreg_q <= shreg_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_q <= ST_FINISH;
        end
        ST_FINISH: begin
          digits_q <= blanked;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.digits = digits_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_bin_to_bcd_digits.sv
// Directed bench for bin_to_bcd_digits (BIN_W=16, DIGITS=5) with a
// scoreboard queue popped by an independent done monitor.
module tb_bin_to_bcd_digits;
  import bin_to_bcd_digits_pkg::*;

  localparam int BIN_W  = 16;
  localparam int DIGITS = 5;
  localparam int DW     = 4 * DIGITS;
  localparam int LAT    = BIN_W + 1;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t state;

  bin_to_bcd_digits_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus_if ();

  bin_to_bcd_digits #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_if),
    .state_o (state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (bus_if.done === 1'b1) begin
      check("busy_with_done", 32'(bus_if.busy), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got digits %h required no done", bus_if.digits);
      end else begin
        mon_exp = exp_q.pop_front();
        check("digits", 32'(bus_if.digits), 32'(mon_exp));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after the accepting edge; counts edges until done (bounded).
  task automatic wait_done(output int edges, output int busy_cnt);
    edges    = 0;
    busy_cnt = int'(bus_if.busy);
    while (edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (bus_if.done === 1'b1) break;
      busy_cnt += int'(bus_if.busy);
    end
  endtask

  task automatic convert(input logic [BIN_W-1:0] b, input logic blz, input logic [DW-1:0] e);
    int edges, busy_cnt;
    @(negedge clk);
    bus_if.start    = 1'b1;
    bus_if.bin      = b;
    bus_if.blank_lz = blz;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus_if.start    = 1'b0;
    bus_if.bin      = ~b;      // must not affect the running conversion
    bus_if.blank_lz = ~blz;
    wait_done(edges, busy_cnt);
    check("latency", 32'(edges), 32'(LAT));
    check("busy_cycles", 32'(busy_cnt), 32'(LAT));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int edges, busy_cnt;
    bus_if.start    = 1'b0;
    bus_if.bin      = '0;
    bus_if.blank_lz = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_digits", 32'(bus_if.digits), 32'hFFFFF);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("idle_digits", 32'(bus_if.digits), 32'hFFFFF);
    check("idle_busy", 32'(bus_if.busy), 32'd0);
    check("idle_done", 32'(bus_if.done), 32'd0);
    check("idle_state", 32'(state), 32'(ST_IDLE));

    // Directed conversions
    convert(16'd1234,  1'b1, 20'hF1234);
    convert(16'd0,     1'b1, 20'hFFFF0);
    convert(16'd0,     1'b0, 20'h00000);
    convert(16'd65535, 1'b0, 20'h65535);
    convert(16'd40009, 1'b1, 20'h40009);
    convert(16'd100,   1'b1, 20'hFF100);

    // Back-to-back with start held high; bin changes mid-conversion
    @(negedge clk);
    bus_if.start    = 1'b1;
    bus_if.bin      = 16'd7;
    bus_if.blank_lz = 1'b0;
    exp_q.push_back(20'h00007);
    exp_q.push_back(20'h00008);
    @(posedge clk);
    #1;
    bus_if.bin = 16'd8;
    wait_done(edges, busy_cnt);
    check("b2b_latency1", 32'(edges), 32'(LAT));
    @(posedge clk);
    #1;
    check("b2b_accept", 32'(bus_if.busy), 32'd1);
    bus_if.start = 1'b0;
    bus_if.bin   = 16'd4321;
    @(posedge clk);
    #1;
    bus_if.start = 1'b1;         // pulse while busy: ignored
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    wait_done(edges, busy_cnt);
    check("b2b_latency2", 32'(edges), 32'(LAT - 2));
    @(posedge clk);
    #1;
    check("b2b_idle_busy", 32'(bus_if.busy), 32'd0);
    check("b2b_idle_state", 32'(state), 32'(ST_IDLE));

    // Reset mid-conversion aborts without done
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.bin   = 16'd999;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus_if.busy), 32'd0);
    check("abort_done", 32'(bus_if.done), 32'd0);
    check("abort_digits", 32'(bus_if.digits), 32'hFFFFF);
    check("abort_state", 32'(state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("abort_hold_digits", 32'(bus_if.digits), 32'hFFFFF);
    convert(16'd5, 1'b0, 20'h00005);

    repeat (5) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
